// File: rtl/seg7_scan_decoder_pkg.sv
// Shared types and segment constants for the 7-segment display reader.
// Patterns are active-high abcdefg with segment a in bit 6.
package seg7_scan_decoder_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STROBE = 3'd1,
    S_SAMPLE = 3'd2,
    S_GAP    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [6:0] SEG_0   = 7'b1111110;
  localparam logic [6:0] SEG_1   = 7'b0110000;
  localparam logic [6:0] SEG_2   = 7'b1101101;
  localparam logic [6:0] SEG_3   = 7'b1111001;
  localparam logic [6:0] SEG_4   = 7'b0110011;
  localparam logic [6:0] SEG_5   = 7'b1011011;
  localparam logic [6:0] SEG_6   = 7'b0011111;
  localparam logic [6:0] SEG_7   = 7'b1110000;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1110011;
  localparam logic [6:0] SEG_A   = 7'b0001101;
  localparam logic [6:0] SEG_B   = 7'b0011001;
  localparam logic [6:0] SEG_C   = 7'b0100011;
  localparam logic [6:0] SEG_D   = 7'b1001011;
  localparam logic [6:0] SEG_E   = 7'b0001111;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // Bus carries seg_n[0]=a .. seg_n[6]=g, active low.
  function automatic logic [6:0] seg_to_pat(
    input logic [6:0] seg_n
  );
    logic [6:0] p;
    for (int k = 0; k < 7; k++) begin
      p[6-k] = ~seg_n[k];
    end
    return p;
  endfunction

endpackage

// File: rtl/seg7_scan_decoder_decode.sv
// Combinational segment-pattern to value decoder.
// Blank and unrecognised patterns both report value 4'hF.
module seg7_pattern_decode
  import seg7_scan_decoder_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] val,
  output logic       blank,
  output logic       err
);

  always_comb begin
    val   = 4'hF;
    blank = 1'b0;
    err   = 1'b0;
    unique case (pat)
      SEG_0:   val = 4'h0;
      SEG_1:   val = 4'h1;
      SEG_2:   val = 4'h2;
      SEG_3:   val = 4'h3;
      SEG_4:   val = 4'h4;
      SEG_5:   val = 4'h5;
      SEG_6:   val = 4'h6;
      SEG_7:   val = 4'h7;
      SEG_8:   val = 4'h8;
      SEG_9:   val = 4'h9;
      SEG_A:   val = 4'hA;
      SEG_B:   val = 4'hB;
      SEG_C:   val = 4'hC;
      SEG_D:   val = 4'hD;
      SEG_E:   val = 4'hE;
      SEG_OFF: blank = 1'b1;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Multiplexed display reader: strobes each digit, debounces
// the segment bus and decodes it back to a value.
module seg7_scan_decoder
  import seg7_scan_decoder_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int SETTLE = 3,
  parameter int STABLE = 2,
  parameter int MAXTRY = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [6:0]            seg_n,
  output logic [DIGITS-1:0]     dig_n,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank,
  output logic [DIGITS-1:0]     err
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
  localparam logic [7:0] SET_END = 8'(SETTLE - 1);
  localparam logic [7:0] STB     = 8'(STABLE);
  localparam logic [7:0] MXT     = 8'(MAXTRY);

  state_t st, st_d;
  logic [IW-1:0] idx, idx_d;
  logic [7:0] cnt, cnt_d;
  logic [7:0] tries, tries_d;
  logic [7:0] mcnt, mcnt_d;
  logic [7:0] m_new;
  logic [6:0] refp, refp_d;

  logic [4*DIGITS-1:0] sh_bcd, sh_bcd_d, bcd_d;
  logic [DIGITS-1:0] sh_blank, sh_blank_d, blank_d;
  logic [DIGITS-1:0] sh_err, sh_err_d, err_d;

  logic [6:0] pat;
  logic [3:0] dval;
  logic       dblank;
  logic       derr;

  logic       commit;
  logic [3:0] c_val;
  logic       c_blank;
  logic       c_err;

  assign pat = seg_to_pat(seg_n);

  seg7_pattern_decode u_dec (
    .pat   (pat),
    .val   (dval),
    .blank (dblank),
    .err   (derr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= S_IDLE;
      idx      <= '0;
      cnt      <= '0;
      tries    <= '0;
      mcnt     <= '0;
      refp     <= '0;
      sh_bcd   <= '1;
      sh_blank <= '0;
      sh_err   <= '0;
      bcd      <= '1;
      blank    <= '0;
      err      <= '0;
    end else begin
      st       <= st_d;
      idx      <= idx_d;
      cnt      <= cnt_d;
      tries    <= tries_d;
      mcnt     <= mcnt_d;
      refp     <= refp_d;
      sh_bcd   <= sh_bcd_d;
      sh_blank <= sh_blank_d;
      sh_err   <= sh_err_d;
      bcd      <= bcd_d;
      blank    <= blank_d;
      err      <= err_d;
    end
  end

  always_comb begin
    st_d       = st;
    idx_d      = idx;
    cnt_d      = cnt;
    tries_d    = tries;
    mcnt_d     = mcnt;
    refp_d     = refp;
    m_new      = 8'd1;
    sh_bcd_d   = sh_bcd;
    sh_blank_d = sh_blank;
    sh_err_d   = sh_err;
    bcd_d      = bcd;
    blank_d    = blank;
    err_d      = err;
    commit     = 1'b0;
    c_val      = 4'hF;
    c_blank    = 1'b0;
    c_err      = 1'b0;
    unique case (st)
      S_IDLE: begin
        if (start) begin
          st_d  = S_STROBE;
          idx_d = '0;
          cnt_d = '0;
        end
      end
      S_STROBE: begin
        if (cnt == SET_END) begin
          st_d    = S_SAMPLE;
          cnt_d   = '0;
          tries_d = '0;
          mcnt_d  = '0;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      S_SAMPLE: begin
        tries_d = tries + 8'd1;
        // An unknown compare falls to the reload branch.
        if (tries != 8'd0 && pat == refp) begin
          m_new = mcnt + 8'd1;
        end else begin
          m_new = 8'd1;
        end
        refp_d = pat;
        mcnt_d = m_new;
        if (m_new == STB) begin
          commit  = 1'b1;
          c_val   = dval;
          c_blank = dblank;
          c_err   = derr;
        end else if (tries_d == MXT) begin
          commit = 1'b1;
          c_err  = 1'b1;
        end
      end
      S_GAP: begin
        st_d  = S_STROBE;
        idx_d = idx + IW'(1);
        cnt_d = '0;
      end
      S_DONE: st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
    if (commit) begin
      sh_bcd_d[4*idx +: 4] = c_val;
      sh_blank_d[idx]      = c_blank;
      sh_err_d[idx]        = c_err;
      tries_d              = '0;
      mcnt_d               = '0;
      if (idx == LAST) begin
        // Publish all digits together as done rises.
        st_d    = S_DONE;
        bcd_d   = sh_bcd_d;
        blank_d = sh_blank_d;
        err_d   = sh_err_d;
      end else begin
        st_d = S_GAP;
      end
    end
  end

  always_comb begin
    dig_n = '1;
    busy  = 1'b0;
    done  = 1'b0;
    unique case (st)
      S_STROBE, S_SAMPLE: begin
        dig_n[idx] = 1'b0;
        busy       = 1'b1;
      end
      S_GAP:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Randomized bench for seg7_scan_decoder with a display model
// driving the segment bus and a sample-list reference model.
module tb_seg7_scan_decoder;

  localparam int D  = 4;
  localparam int ST = 3;
  localparam int SB = 2;
  localparam int MT = 8;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [6:0] seg_n;
  logic [D-1:0] dig_n;
  logic busy;
  logic done;
  logic [4*D-1:0] bcd;
  logic [D-1:0] blank;
  logic [D-1:0] err;

  seg7_scan_decoder #(
    .DIGITS (D),
    .SETTLE (ST),
    .STABLE (SB),
    .MAXTRY (MT)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .seg_n (seg_n),
    .dig_n (dig_n),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .blank (blank),
    .err   (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [6:0] tab [15] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b0011111, 7'b1110000,
    7'b1111111, 7'b1110011, 7'b0001101, 7'b0011001,
    7'b0100011, 7'b1001011, 7'b0001111
  };

  logic [6:0] seq [D][MT];
  int k [D];

  logic [4*D-1:0] exp_bcd, prev_bcd;
  logic [D-1:0] exp_blank, prev_blank;
  logic [D-1:0] exp_err, prev_err;
  int exp_cyc;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] enc(input logic [6:0] p);
    logic [6:0] r;
    for (int i = 0; i < 7; i++) r[i] = ~p[6-i];
    return r;
  endfunction

  // Display model: the j-th sample of a strobed digit is seq[d][j].
  always @(negedge clk) begin
    bit any;
    any = 0;
    for (int i = 0; i < D; i++) begin
      if (dig_n[i] === 1'b0) begin
        any = 1;
        if (k[i] >= ST && k[i] - ST < MT) seg_n = enc(seq[i][k[i]-ST]);
        else seg_n = 7'($urandom);
        k[i]++;
      end else begin
        k[i] = 0;
      end
    end
    if (!any) seg_n = 7'($urandom);
  end

  task automatic decode_pat(input logic [6:0] p, output logic [3:0] v,
                            output bit b, output bit e);
    v = 4'hF; b = 0; e = 1;
    if (p == 7'd0) begin
      b = 1; e = 0;
    end else begin
      for (int c = 0; c < 15; c++)
        if (tab[c] == p) begin v = 4'(c); e = 0; end
    end
  endtask

  task automatic model_scan();
    int cyc;
    cyc = 1;
    for (int d = 0; d < D; d++) begin
      int run, s;
      bit got;
      logic [3:0] v;
      bit b, e;
      run = 0; got = 0; s = MT;
      v = 4'hF; b = 0; e = 1;
      for (int j = 0; j < MT && !got; j++) begin
        if (j == 0 || seq[d][j] != seq[d][j-1]) run = 1;
        else run++;
        if (run == SB) begin
          decode_pat(seq[d][j], v, b, e);
          got = 1; s = j + 1;
        end
      end
      exp_bcd[4*d +: 4] = v;
      exp_blank[d] = b;
      exp_err[d] = e;
      cyc += ST + s;
      if (d < D - 1) cyc++;
    end
    exp_cyc = cyc;
  endtask

  task automatic steady(input int d, input logic [6:0] p);
    for (int j = 0; j < MT; j++) seq[d][j] = p;
  endtask

  task automatic toggle(input int d, input logic [6:0] a,
                        input logic [6:0] b);
    for (int j = 0; j < MT; j++) seq[d][j] = (j % 2) ? b : a;
  endtask

  task automatic rand_setup();
    for (int d = 0; d < D; d++) begin
      int v, w;
      logic [6:0] p;
      logic [3:0] vv;
      bit bb, ee;
      v = $urandom_range(0, 14);
      w = (v + 1 + $urandom_range(0, 13)) % 15;
      case ($urandom_range(0, 5))
        0: steady(d, tab[v]);
        1: steady(d, 7'd0);
        2: begin
          do begin
            p = 7'($urandom);
            decode_pat(p, vv, bb, ee);
          end while (!ee);
          steady(d, p);
        end
        3: begin
          steady(d, tab[v]);
          seq[d][0] = tab[w];
        end
        4: toggle(d, tab[v], tab[w]);
        default:
          for (int j = 0; j < MT; j++) seq[d][j] = 7'($urandom);
      endcase
    end
  endtask

  task automatic run_scan(input bit repulse);
    int n;
    bit seen, viol, held, late;
    model_scan();
    @(negedge clk);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    n = 0; seen = 0; viol = 0; held = 1;
    while (!seen && n < 400) begin
      int z;
      @(negedge clk);
      n++;
      if (n == 1) chk("busy_c1", busy, 1);
      if (repulse && n == 5) start = 1;
      if (repulse && n == 6) start = 0;
      z = 0;
      for (int i = 0; i < D; i++) if (dig_n[i] !== 1'b1) z++;
      if (z > 1) viol = 1;
      if (done === 1'b1) seen = 1;
      else if (bcd !== prev_bcd || blank !== prev_blank ||
               err !== prev_err) held = 0;
    end
    chk("done_seen", seen, 1);
    chk("done_cyc", n, exp_cyc);
    chk("busy_done", busy, 0);
    chk("bcd", bcd, exp_bcd);
    chk("blank", blank, exp_blank);
    chk("err", err, exp_err);
    chk("hold", held, 1);
    chk("onehot", viol, 0);
    prev_bcd = exp_bcd;
    prev_blank = exp_blank;
    prev_err = exp_err;
    if (repulse) begin
      late = 0;
      repeat (30) begin
        @(negedge clk);
        if (done !== 1'b0) late = 1;
      end
      chk("single_done", late, 0);
    end
  endtask

  initial begin
    bit late;
    rst = 1; start = 0; seg_n = '0;
    for (int i = 0; i < D; i++) k[i] = 0;
    prev_bcd = '1; prev_blank = '0; prev_err = '0;
    repeat (3) @(negedge clk);
    rst = 0;
    chk("rst_dig", dig_n, 4'hF);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bcd", bcd, 16'hFFFF);
    chk("rst_blank", blank, 0);
    chk("rst_err", err, 0);

    for (int d = 0; d < D; d++) steady(d, tab[d+1]);
    run_scan(0);
    chk("t2_cyc", exp_cyc, 24);
    chk("t2_bcd", bcd, 16'h4321);

    @(negedge clk);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (10) @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    chk("mrst_dig", dig_n, 4'hF);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_bcd", bcd, 16'hFFFF);
    chk("mrst_blank", blank, 0);
    chk("mrst_err", err, 0);
    rst = 0;
    late = 0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0) late = 1;
    end
    chk("mrst_nodone", late, 0);
    prev_bcd = '1; prev_blank = '0; prev_err = '0;

    steady(0, tab[1]); steady(1, tab[6]);
    steady(2, 7'd0); steady(3, tab[14]);
    run_scan(0);
    chk("t3_bcd", bcd, 16'hEF61);
    chk("t3_blank", blank, 4'b0100);

    steady(0, tab[0]); seq[0][0] = 7'b1111100;
    steady(1, tab[9]); steady(2, tab[8]); steady(3, tab[7]);
    run_scan(0);
    chk("t4_cyc", exp_cyc, 25);
    chk("t4_bcd", bcd, 16'h7890);

    toggle(1, tab[2], tab[3]);
    run_scan(0);
    chk("t4_err", err, 4'b0010);
    chk("t4_bcd1", bcd, 16'h78F0);

    steady(0, tab[2]); steady(1, tab[5]);
    steady(2, tab[9]); steady(3, 7'b1000000);
    run_scan(0);
    chk("t5_err", err, 4'b1000);
    chk("t5_bcd", bcd, 16'hF952);

    rand_setup();
    run_scan(1);
    rand_setup();
    run_scan(0);
    rand_setup();
    run_scan(0);

    for (int r = 0; r < 20; r++) begin
      rand_setup();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_scan(r % 5 == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
Reverse path of the BCD-to-7-segment decoder family. The block scans a multiplexed common-anode display bus and drives one active-low digit strobe at a time. It samples the active-low open-collector segment lines, waits for each digit to settle and debounces it, then decodes the segment pattern back to a 4-bit code with blank and error flags. It sits in test benches and board models as the "display reader", so decoder outputs can be checked numerically rather than by segment pattern.

Parameters:
DIGITS, 4, number of multiplexed digits scanned (1..8)
SETTLE, 3, clocks a strobe is held before the first sample (>=1)
STABLE, 2, consecutive identical samples required to accept a digit (>=1)
MAXTRY, 8, maximum samples per digit before declaring error (>=STABLE)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active high
start  in  1  begin one full scan; sampled only in IDLE
seg_n  in  7  segment lines, active low; seg_n[0]=a ... seg_n[6]=g
dig_n  out  DIGITS  digit strobes, active low, at most one low
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse; results valid from this cycle on
bcd  out  4*DIGITS  decoded values, digit i in bcd[4i+3:4i]
blank  out  DIGITS  digit i showed no segments
err  out  DIGITS  digit i unrecognised or unstable

Behaviour:
- Reset: dig_n all 1, busy=0, done=0, bcd all 1s (4'hF per digit), blank all 0, err all 0, FSM to IDLE, all counters 0.
- Reset during a scan aborts it. No done pulse. Outputs return to reset values.
- States: IDLE -> STROBE -> SAMPLE -> GAP -> STROBE ... -> DONE -> IDLE.
- IDLE: dig_n all 1. When start=1, go to STROBE with digit index 0. start is ignored in all other states.
- STROBE: dig_n[idx]=0 for SETTLE cycles. seg_n is ignored.
- SAMPLE: dig_n[idx] stays 0. Sample seg_n every cycle.
  - First sample loads ref and sets match count to 1.
  - A sample equal to ref increments the count. An unequal sample reloads ref and resets the count to 1.
  - When the count reaches STABLE, commit the decode of ref.
  - If MAXTRY samples pass without commit, commit err=1 with bcd=F.
- GAP: one cycle with dig_n all 1, then idx+1 enters STROBE. The last digit goes straight to DONE with no GAP.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- Commits go to shadow registers. bcd, blank and err update atomically on the cycle done rises and hold until the next done or reset.
- Timing with steady input: each non-last digit takes SETTLE+STABLE+1 cycles. With defaults, start sampled at cycle 0 gives done at cycle 1+3*6+5 = 24.
- Decode table uses active-high segments abcdefg (a=MSB of the pattern shown):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=0011111 (no tail), 7=1110000, 8=1111111, 9=1110011 (no tail)
  - 10=0001101, 11=0011001, 12=0100011, 13=1001011, 14=0001111
  - 0000000 -> blank=1, bcd=F, err=0
  - any other pattern -> err=1, bcd=F, blank=0
- Codes 10..14 are legal decoder outputs and are reported as their value with err=0.
- Lamp test and code 8 are indistinguishable; both report 8.
- X/Z on seg_n counts as unequal to ref and as an unknown pattern.

Decomposition:
- Shared include seg7_defs.vh holds the 16 segment-pattern constants (shared with the decoder models' benches) and the FSM state encodings.
- One combinational sub-module, seg7_pattern_decode: 7-bit active-high pattern in; 4-bit value, blank and err out.
- Sequencing and debounce stay in seg7_scan_decoder.

Test Plan:
1. Reset: assert rst for 2 cycles mid-scan -> dig_n=4'b1111, busy=0, done=0, bcd=16'hFFFF, blank=0, err=0; no done pulse follows.
2. Behavioural display model shows digits 0..3 = 1,2,3,4, start pulse at cycle 0 -> done exactly at cycle 24, bcd=16'h4321, blank=0, err=0; exactly one dig_n bit low at any time.
3. Digit 2 all segments off, digit 1 shows 6 (0011111), digit 3 shows 14 -> bcd=16'hEF61, blank=4'b0100, err=0.
4. Digit 0 shows the 1111110 pattern with a glitch on the first sample -> one extra sample cycle (done at 25), bcd[3:0]=0, err[0]=0. Digit 1 toggling every cycle -> err[1]=1, bcd[7:4]=F after MAXTRY samples.
5. Digit 3 shows 1000000 (unknown) -> err=4'b1000, bcd[15:12]=F, other digits decoded normally.
6. start re-pulsed while busy -> ignored, single done. Back-to-back start on the cycle after done -> second scan completes, results replaced atomically.
